// File: rtl/instr_fifo.sv
// Instruction FIFO: assembles 80-bit TPU instructions from three host register writes and queues them.
// Latency: a commit at edge N makes the entry visible after edge N. The head is shown without a read request.
// Backpressure: a commit while full is dropped unless a pop frees a slot in the same cycle. The consumer holds off with instr_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   lower_word/_we      instruction bits [31:0] and its staging write strobe
//   middle_word/_we     instruction bits [63:32] and its staging write strobe
//   upper_halfword/_we  instruction bits [79:64]; the strobe commits the full instruction
//   instr_out/_valid    head entry (all-zero when empty) and non-empty flag
//   instr_ready         consumer accepts the head entry this cycle
//   full, count         occupancy status, both registered
//   overflow, overflow_clr  sticky dropped-commit flag and its clear;
//                       these two ports exist only when INSTR_FIFO_OVERFLOW_EN is defined

package tpu_pkg;

    // Field layout of an 80-bit instruction, MSB first.
    typedef struct packed {
        logic [23:0] buffer_addr;  // [79:56]
        logic [15:0] acc_addr;     // [55:40]
        logic [31:0] length;       // [39:8]
        logic [7:0]  opcode;       // [7:0]
    } instr_type;

    function automatic instr_type bit_to_instr(input logic [79:0] raw);
        instr_type i;
        i.buffer_addr = raw[79:56];
        i.acc_addr    = raw[55:40];
        i.length      = raw[39:8];
        i.opcode      = raw[7:0];
        return i;
    endfunction

endpackage

module instr_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              lower_word,
    input  logic                     lower_we,
    input  logic [31:0]              middle_word,
    input  logic                     middle_we,
    input  logic [15:0]              upper_halfword,
    input  logic                     upper_we,
    output tpu_pkg::instr_type       instr_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     full,
`ifdef INSTR_FIFO_OVERFLOW_EN
    output logic                     overflow,
    input  logic                     overflow_clr,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [31:0] lower_q;
    logic [31:0] middle_q;
    logic [79:0] mem [DEPTH];

    // Pointers carry one extra MSB so full and empty stay distinguishable after wrap.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_q;

    logic [31:0] lower_sel;
    logic [31:0] middle_sel;
    logic [79:0] commit_dat;
    logic        push;
    logic        pop;

    assign instr_valid = (count_q != '0);
    assign full        = (count_q == DEPTH_C);
    assign count       = count_q;

    assign pop  = instr_valid && instr_ready;
    // A pop in the same cycle frees a slot, so a commit into a full FIFO still lands.
    assign push = upper_we && (!full || pop);

    // Words written in the committing cycle bypass their staging registers.
    assign lower_sel  = lower_we  ? lower_word  : lower_q;
    assign middle_sel = middle_we ? middle_word : middle_q;
    assign commit_dat = {upper_halfword, middle_sel, lower_sel};

    // Staging registers persist across commits so instructions can share lower/middle words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lower_q  <= '0;
            middle_q <= '0;
        end else begin
            if (lower_we) begin
                lower_q <= lower_word;
            end
            if (middle_we) begin
                middle_q <= middle_word;
            end
        end
    end

    // Storage needs no reset: the output is gated by instr_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= commit_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        instr_out = '0;
        if (instr_valid) begin
            instr_out = tpu_pkg::bit_to_instr(mem[rd_ptr[AW-1:0]]);
        end
    end

`ifdef INSTR_FIFO_OVERFLOW_EN
    logic drop;
    logic overflow_q;

    assign drop     = upper_we && !push;
    assign overflow = overflow_q;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fifo.sv
// Directed bench for instr_fifo at DEPTH=4.
// Each task drives one scenario and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_instr_fifo;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        lower_word;
    logic               lower_we;
    logic [31:0]        middle_word;
    logic               middle_we;
    logic [15:0]        upper_halfword;
    logic               upper_we;
    tpu_pkg::instr_type instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic               full;
    logic [2:0]         count;
`ifdef INSTR_FIFO_OVERFLOW_EN
    logic               overflow;
    logic               overflow_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .lower_word     (lower_word),
        .lower_we       (lower_we),
        .middle_word    (middle_word),
        .middle_we      (middle_we),
        .upper_halfword (upper_halfword),
        .upper_we       (upper_we),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .full           (full),
`ifdef INSTR_FIFO_OVERFLOW_EN
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
`endif
        .count          (count)
    );

    // Drive one cycle of inputs, wait past the edge, then return inputs to idle.
    task automatic step(input logic lwe, input logic [31:0] lw,
                        input logic mwe, input logic [31:0] mw,
                        input logic uwe, input logic [15:0] uw,
                        input logic rdy);
        lower_we = lwe; lower_word = lw;
        middle_we = mwe; middle_word = mw;
        upper_we = uwe; upper_halfword = uw;
        instr_ready = rdy;
        @(posedge clk);
        #1;
        lower_we = 1'b0; middle_we = 1'b0; upper_we = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lower_word = '0; lower_we = 1'b0; middle_word = '0; middle_we = 1'b0;
        upper_halfword = '0; upper_we = 1'b0; instr_ready = 1'b0;
`ifdef INSTR_FIFO_OVERFLOW_EN
        overflow_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", instr_valid); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (instr_out !== 80'h0) begin failures++; $display("FAIL reset_instr_out got=%h exp=0", instr_out); end
`ifdef INSTR_FIFO_OVERFLOW_EN
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        step(1'b1, 32'h1234_5678, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h9ABC_DEF0, 1'b0, '0, 1'b0);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL single_staged_valid got=%0h exp=0", instr_valid); end
        step(1'b0, '0, 1'b0, '0, 1'b1, 16'h1122, 1'b0);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr_out.buffer_addr !== 24'h11229A) begin failures++; $display("FAIL single_buffer_addr got=%h exp=11229a", instr_out.buffer_addr); end
        checks++; if (instr_out.acc_addr !== 16'hBCDE) begin failures++; $display("FAIL single_acc_addr got=%h exp=bcde", instr_out.acc_addr); end
        checks++; if (instr_out.length !== 32'hF012_3456) begin failures++; $display("FAIL single_length got=%h exp=f0123456", instr_out.length); end
        checks++; if (instr_out.opcode !== 8'h78) begin failures++; $display("FAIL single_opcode got=%h exp=78", instr_out.opcode); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr_out !== 80'h0) begin failures++; $display("FAIL single_pop_out got=%h exp=0", instr_out); end
        // A pop while empty must be ignored.
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        step(1'b1, 32'hAAAA_AA01, 1'b1, 32'h0, 1'b1, 16'h0000, 1'b0);
        checks++; if (instr_out.opcode !== 8'h01) begin failures++; $display("FAIL bypass_opcode got=%h exp=01", instr_out.opcode); end
        checks++; if (instr_out.length !== 32'h00AA_AAAA) begin failures++; $display("FAIL bypass_length got=%h exp=00aaaaaa", instr_out.length); end
        checks++; if (instr_out.buffer_addr !== 24'h0) begin failures++; $display("FAIL bypass_buffer_addr got=%h exp=0", instr_out.buffer_addr); end
        // Upper-only commit reuses the staged lower/middle words written by the bypass.
        step(1'b0, '0, 1'b0, '0, 1'b1, 16'h00FF, 1'b0);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL bypass_count got=%0d exp=2", count); end
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        checks++; if (instr_out.opcode !== 8'h01) begin failures++; $display("FAIL staged_opcode got=%h exp=01", instr_out.opcode); end
        checks++; if (instr_out.length !== 32'h00AA_AAAA) begin failures++; $display("FAIL staged_length got=%h exp=00aaaaaa", instr_out.length); end
        checks++; if (instr_out.buffer_addr !== 24'h00FF00) begin failures++; $display("FAIL staged_buffer_addr got=%h exp=00ff00", instr_out.buffer_addr); end
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_fill_overflow();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 32'(k), 1'b0, '0, 1'b1, '0, 1'b0);
            if (k == 4) begin
                checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0h exp=1", full); end
                checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
            end
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL drop_count got=%0d exp=4", count); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL drop_full got=%0h exp=1", full); end
`ifdef INSTR_FIFO_OVERFLOW_EN
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0h exp=1", overflow); end
        overflow_clr = 1'b1;
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clr got=%0h exp=0", overflow); end
        // Drop and clear in the same cycle: set wins.
        step(1'b1, 32'h6, 1'b0, '0, 1'b1, '0, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set_wins got=%0h exp=1", overflow); end
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        overflow_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clr2 got=%0h exp=0", overflow); end
`endif
        for (int k = 1; k <= 4; k++) begin
            checks++; if (instr_out.opcode !== 8'(k)) begin failures++; $display("FAIL drain_opcode got=%h exp=%h", instr_out.opcode, 8'(k)); end
            step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_push_pop_full();
        for (int k = 5; k <= 8; k++) begin
            step(1'b1, 32'(k), 1'b0, '0, 1'b1, '0, 1'b0);
        end
        step(1'b1, 32'h9, 1'b0, '0, 1'b1, '0, 1'b1);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL pp_full_count got=%0d exp=4", count); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL pp_full_full got=%0h exp=1", full); end
        for (int k = 6; k <= 9; k++) begin
            checks++; if (instr_out.opcode !== 8'(k)) begin failures++; $display("FAIL pp_full_order got=%h exp=%h", instr_out.opcode, 8'(k)); end
            step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL pp_full_empty got=%0h exp=0", instr_valid); end
    endtask

    task automatic test_wrap();
        int   q[$];
        int   pushed = 0;
        int   popped = 0;
        logic do_push;
        logic do_pop;
        for (int c = 0; c < 60 && popped < 10; c++) begin
            do_push = (pushed < 10) && (c % 4 != 3);
            do_pop  = (q.size() > 0) && (q.size() == 3 || pushed == 10 || c % 5 == 4);
            if (do_pop) begin
                checks++; if (instr_out.opcode !== 8'(q[0])) begin failures++; $display("FAIL wrap_order got=%h exp=%h", instr_out.opcode, 8'(q[0])); end
            end
            step(do_push, 32'(8'h40 + pushed), 1'b0, '0, do_push, '0, do_pop);
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(8'h40 + pushed);
                pushed++;
            end
            checks++; if (int'(count) !== q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count, q.size()); end
            checks++; if (instr_valid !== (q.size() != 0)) begin failures++; $display("FAIL wrap_valid got=%0h exp=%0h", instr_valid, q.size() != 0); end
        end
        checks++; if (popped !== 10) begin failures++; $display("FAIL wrap_popped got=%0d exp=10", popped); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h21, 1'b0, '0, 1'b1, '0, 1'b0);
        step(1'b1, 32'h22, 1'b0, '0, 1'b1, '0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h5555_5555, 1'b0, '0, 1'b0);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0h exp=0", instr_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        checks++; if (instr_out !== 80'h0) begin failures++; $display("FAIL mid_rst_out got=%h exp=0", instr_out); end
        #1 rst = 1'b0;
        step(1'b0, '0, 1'b0, '0, 1'b1, 16'h0001, 1'b0);
        checks++; if (instr_out.buffer_addr !== 24'h000100) begin failures++; $display("FAIL mid_buffer_addr got=%h exp=000100", instr_out.buffer_addr); end
        checks++; if (instr_out.acc_addr !== 16'h0) begin failures++; $display("FAIL mid_acc_addr got=%h exp=0", instr_out.acc_addr); end
        checks++; if (instr_out.length !== 32'h0) begin failures++; $display("FAIL mid_length got=%h exp=0", instr_out.length); end
        checks++; if (instr_out.opcode !== 8'h0) begin failures++; $display("FAIL mid_opcode got=%h exp=0", instr_out.opcode); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", count); end
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_bypass();
        test_fill_overflow();
        test_push_pop_full();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
